// File: rtl/key_event_decoder_pkg.sv
// Shared types and default timing constants for the key event decoder.
// Default counts assume a 50 MHz system clock.
package key_evt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_WAIT_GAP,
        ST_PRESSED2,
        ST_LONG_HELD
    } key_state_t;

    localparam int unsigned LONG_CNT    = 50_000_000;
    localparam int unsigned DBL_GAP_CNT = 15_000_000;
    localparam int unsigned REPEAT_CNT  = 10_000_000;

    // A level held through reset must not look like a fresh press.
    localparam logic PREV_LEVEL_RST = 1'b1;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_event_decoder_if.sv
// Button level in, event pulses out; the decoder uses the slave modport.
interface key_event_decoder_if;

    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic short_pulse;
    logic double_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic busy;

    modport master (
        output btn_level,
        input  press_pulse, release_pulse, short_pulse, double_pulse,
        input  long_pulse, repeat_pulse, busy
    );

    modport slave (
        input  btn_level,
        output press_pulse, release_pulse, short_pulse, double_pulse,
        output long_pulse, repeat_pulse, busy
    );

endinterface

// File: rtl/key_event_decoder_level_edge_det.sv
// Registered previous level with combinational rise/fall detection.
module level_edge_det #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic rise_c_o,
    output logic fall_c_o
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) prev_q <= RST_VAL;
        else     prev_q <= level_i;
    end

    assign rise_c_o = level_i & ~prev_q;
    assign fall_c_o = ~level_i & prev_q;

endmodule

// File: rtl/key_event_decoder.sv
// Turns a debounced button level into press/release/short/double/long pulses.
// Optional auto-repeat while long-held is enabled by defining KEY_REPEAT_EN.
module key_event_decoder #(
    parameter int unsigned LONG_CNT    = key_evt_pkg::LONG_CNT,
    parameter int unsigned DBL_GAP_CNT = key_evt_pkg::DBL_GAP_CNT,
    parameter int unsigned REPEAT_CNT  = key_evt_pkg::REPEAT_CNT
) (
    input logic                 clk,
    input logic                 rst,
    key_event_decoder_if.slave  key_if
);
    import key_evt_pkg::*;

    localparam int unsigned MAX_CNT = max3(LONG_CNT, DBL_GAP_CNT, REPEAT_CNT);
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CNT - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 1);
`endif

    logic rise_c, fall_c;

    level_edge_det #(.RST_VAL(PREV_LEVEL_RST)) u_edge (
        .clk      (clk),
        .rst      (rst),
        .level_i  (key_if.btn_level),
        .rise_c_o (rise_c),
        .fall_c_o (fall_c)
    );

    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic press_q,  press_d;
    logic rel_q,    rel_d;
    logic short_q,  short_d;
    logic dbl_q,    dbl_d;
    logic long_q,   long_d;
    logic rep_q,    rep_d;
    logic busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            short_q <= 1'b0;
            dbl_q   <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            short_q <= short_d;
            dbl_q   <= dbl_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // Next state, counter and pulse decode; edge pulses pass through by default.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        press_d = rise_c;
        rel_d   = fall_c && (state_q != ST_IDLE);
        short_d = 1'b0;
        dbl_d   = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rise_c) state_d = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (fall_c) begin
                    state_d = ST_WAIT_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = ST_LONG_HELD;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_GAP: begin
                // Timeout beats a coincident rise, which is then not a press.
                if (cnt_q == GAP_LAST) begin
                    short_d = 1'b1;
                    press_d = 1'b0;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (rise_c) begin
                    state_d = ST_PRESSED2;
                    cnt_d   = '0;
                end
            end
            ST_PRESSED2: begin
                if (fall_c) begin
                    dbl_d   = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = ST_LONG_HELD;
                    cnt_d   = '0;
                end
            end
            ST_LONG_HELD: begin
                if (fall_c) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
`ifdef KEY_REPEAT_EN
                    if (cnt_q == REP_LAST) begin
                        rep_d = 1'b1;
                        cnt_d = '0;
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign key_if.press_pulse   = press_q;
    assign key_if.release_pulse = rel_q;
    assign key_if.short_pulse   = short_q;
    assign key_if.double_pulse  = dbl_q;
    assign key_if.long_pulse    = long_q;
    assign key_if.repeat_pulse  = rep_q;
    assign key_if.busy          = busy_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed, table-driven bench for key_event_decoder (LONG=20, GAP=8, REPEAT=5).
module tb_key_event_decoder;

    // Output vector order: {press, release, short, double, long, repeat, busy}
    localparam logic [6:0] P  = 7'b1000000;
    localparam logic [6:0] R  = 7'b0100000;
    localparam logic [6:0] S  = 7'b0010000;
    localparam logic [6:0] D  = 7'b0001000;
    localparam logic [6:0] L  = 7'b0000100;
    localparam logic [6:0] RP = 7'b0000010;
    localparam logic [6:0] B  = 7'b0000001;
    localparam logic [6:0] Z  = 7'b0000000;

    typedef struct {
        logic       rst;
        logic       btn;
        logic [6:0] exp;
        string      tag;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;
    vec_t vecs[$];

    key_event_decoder_if kif();

    key_event_decoder #(
        .LONG_CNT    (20),
        .DBL_GAP_CNT (8),
        .REPEAT_CNT  (5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .key_if (kif)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic b, input logic [6:0] e, input int n,
                       input string tag);
        vec_t v;
        v.rst = r; v.btn = b; v.exp = e; v.tag = tag;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic b, input logic [6:0] exp, input string tag);
        logic [6:0] got;
        @(negedge clk);
        rst = r;
        kif.btn_level = b;
        @(posedge clk);
        #1;
        got = {kif.press_pulse, kif.release_pulse, kif.short_pulse, kif.double_pulse,
               kif.long_pulse, kif.repeat_pulse, kif.busy};
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s (check %0d): got %b required %b", tag, checks, got, exp);
    endtask

    initial begin
        kif.btn_level = 1'b0;

        add(1, 0, Z, 2, "reset");
        add(0, 0, Z, 1, "post_reset_fall");

        add(0, 1, P | B, 1, "short_press");
        add(0, 1, B,     4, "short_hold");
        add(0, 0, R | B, 1, "short_release");
        add(0, 0, B,     7, "short_gap");
        add(0, 0, S,     1, "short_pulse");
        add(0, 0, Z,     2, "short_idle");

        add(0, 1, P | B, 1, "dbl_press1");
        add(0, 1, B,     4, "dbl_hold1");
        add(0, 0, R | B, 1, "dbl_release1");
        add(0, 0, B,     2, "dbl_gap");
        add(0, 1, P | B, 1, "dbl_press2");
        add(0, 1, B,     3, "dbl_hold2");
        add(0, 0, R | D, 1, "dbl_release2");
        add(0, 0, Z,    10, "dbl_no_short");

        add(0, 1, P | B, 1, "tmo_press");
        add(0, 1, B,     2, "tmo_hold");
        add(0, 0, R | B, 1, "tmo_release");
        add(0, 0, B,     7, "tmo_gap");
        add(0, 1, S,     1, "tmo_repress_ignored");
        add(0, 1, Z,     3, "tmo_held_idle");
        add(0, 0, Z,     2, "tmo_release_idle");
        add(0, 1, P | B, 1, "tmo_new_press");
        add(0, 0, R | B, 1, "tmo_new_release");
        add(0, 0, B,     7, "tmo_new_gap");
        add(0, 0, S,     1, "tmo_new_short");

        add(0, 1, P | B, 1, "rstgap_press");
        add(0, 1, B,     1, "rstgap_hold");
        add(0, 0, R | B, 1, "rstgap_release");
        add(0, 0, B,     2, "rstgap_gap");
        add(1, 0, Z,     1, "rstgap_reset");
        add(0, 0, Z,    10, "rstgap_no_short");

        add(1, 1, Z,     1, "held_reset");
        add(0, 1, Z,     4, "held_no_press");
        add(0, 0, Z,     1, "held_release_idle");
        add(0, 1, P | B, 1, "held_new_press");
        add(0, 0, R | B, 1, "held_new_release");
        add(0, 0, B,     7, "held_gap");
        add(0, 0, S,     1, "held_short");
        add(0, 0, Z,     2, "held_idle");

        foreach (vecs[i]) step(vecs[i].rst, vecs[i].btn, vecs[i].exp, vecs[i].tag);

        // Long hold: 32 cycles high, long at +20, repeats at +25 and +30 when enabled.
        step(0, 1, P | B, "long_press");
        for (int k = 1; k < 32; k++) begin
            logic [6:0] e;
            e = B;
            if (k == 20) e = L | B;
`ifdef KEY_REPEAT_EN
            if (k == 25 || k == 30) e = RP | B;
`endif
            step(0, 1, e, "long_hold");
        end
        step(0, 0, R, "long_release");
        for (int k = 0; k < 10; k++) step(0, 0, Z, "long_after");

        // Second press of a double click held past the long threshold.
        step(0, 1, P | B, "p2long_press1");
        step(0, 0, R | B, "p2long_release1");
        step(0, 1, P | B, "p2long_press2");
        for (int k = 1; k < 20; k++) step(0, 1, B, "p2long_hold");
        step(0, 1, L | B, "p2long_long");
        step(0, 0, R, "p2long_release2");
        for (int k = 0; k < 10; k++) step(0, 0, Z, "p2long_after");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
